// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared definitions for the pipeline hazard/stall controller:
//   state_t         - controller FSM states (RUN, DIV_WAIT, MEM_WAIT)
//   NOP_INSTR       - instruction word loaded into a pipe register on flush/bubble
//   MEM_TIMEOUT_DEF - default upper bound on cycles spent waiting for memory
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DIV_WAIT = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int MEM_TIMEOUT_DEF = 16;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// hazard_detect
// Combinational load-use hazard detector. Flags when the instruction in
// execute is a register-writing load whose destination is read by the
// instruction in decode. x0 is never a hazard source.
// Ports:
//   rs1_3, rs2_3         in  5  decode source registers
//   use_rs1_3, use_rs2_3 in  1  decode actually reads rs1 / rs2
//   rd4                  in  5  execute destination register
//   we4, load4           in  1  execute writes register file / is a load
//   hazard               out 1  load-use hazard present
module hazard_detect (
  input  logic [4:0] rs1_3,
  input  logic [4:0] rs2_3,
  input  logic       use_rs1_3,
  input  logic       use_rs2_3,
  input  logic [4:0] rd4,
  input  logic       we4,
  input  logic       load4,
  output logic       hazard
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = use_rs1_3 && (rs1_3 == rd4);
  assign rs2_hit = use_rs2_3 && (rs2_3 == rd4);
  assign hazard  = load4 && we4 && (rd4 != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
// Pipeline stall/flush controller. Resolves, in priority order, control
// redirects, memory back-pressure, multi-cycle divides and load-use hazards,
// and produces the decode/execute stall, flush and bubble controls.
// Ports:
//   clk, nrst                 clock, asynchronous active-low reset
//   rs1_3, rs2_3              in  5  decode source registers
//   use_rs1_3, use_rs2_3      in  1  decode reads rs1 / rs2
//   rd4, we4, load4           in      execute destination / writes / is load
//   div4                      in  1  execute instruction is a divide/remainder
//   div_done                  in  1  divider result valid pulse
//   mem_req4, mem_ready       in  1  execute memory request / memory accepts
//   redirect4                 in  1  taken branch/jump resolved in execute
//   stall_fd, stall_ex        out 1  hold PC+decode reg / hold execute reg
//   flush_de, bubble_ex       out 1  load NOP into decode / execute reg
//   div_start                 out 1  divider start pulse
//   mem_err                   out 1  memory timeout pulse
//   stall_cnt                 out 16 saturating count of stall_fd cycles
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [4:0]  rs1_3,
  input  logic [4:0]  rs2_3,
  input  logic        use_rs1_3,
  input  logic        use_rs2_3,
  input  logic [4:0]  rd4,
  input  logic        we4,
  input  logic        load4,
  input  logic        div4,
  input  logic        div_done,
  input  logic        mem_req4,
  input  logic        mem_ready,
  input  logic        redirect4,
  output logic        stall_fd,
  output logic        stall_ex,
  output logic        flush_de,
  output logic        bubble_ex,
  output logic        div_start,
  output logic        mem_err,
  output logic [15:0] stall_cnt
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_VAL = CW'(MEM_TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);

  state_t        state_reg;
  state_t        state_next;
  logic [CW-1:0] wait_cnt_reg;
  logic [CW-1:0] wait_cnt_next;
  logic [15:0]   stall_cnt_reg;

  logic hazard;
  logic stall_fd_c;
  logic stall_ex_c;
  logic flush_de_c;
  logic bubble_ex_c;
  logic div_start_c;
  logic mem_err_c;

  hazard_detect u_hazard (
    .rs1_3     (rs1_3),
    .rs2_3     (rs2_3),
    .use_rs1_3 (use_rs1_3),
    .use_rs2_3 (use_rs2_3),
    .rd4       (rd4),
    .we4       (we4),
    .load4     (load4),
    .hazard    (hazard)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg    <= ST_RUN;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  // Next state and outputs. div_start is raised in the RUN cycle that moves
  // to DIV_WAIT, so it can only ever fire once per division; mem_err only
  // fires from MEM_WAIT, so the two pulses are mutually exclusive.
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    stall_fd_c    = 1'b0;
    stall_ex_c    = 1'b0;
    flush_de_c    = 1'b0;
    bubble_ex_c   = 1'b0;
    div_start_c   = 1'b0;
    mem_err_c     = 1'b0;
    unique case (state_reg)
      ST_RUN: begin
        if (redirect4) begin
          flush_de_c  = 1'b1;
          bubble_ex_c = 1'b1;
        end else if (mem_req4 && !mem_ready) begin
          stall_fd_c    = 1'b1;
          stall_ex_c    = 1'b1;
          state_next    = ST_MEM_WAIT;
          wait_cnt_next = CNT_ONE;
        end else if (div4) begin
          div_start_c = 1'b1;
          stall_fd_c  = 1'b1;
          stall_ex_c  = 1'b1;
          state_next  = ST_DIV_WAIT;
        end else if (hazard) begin
          // Execute gets a bubble, so the load moves on and the hazard
          // clears by itself after this cycle.
          stall_fd_c  = 1'b1;
          bubble_ex_c = 1'b1;
        end
      end
      ST_DIV_WAIT: begin
        if (div_done) begin
          state_next = ST_RUN;
        end else begin
          stall_fd_c = 1'b1;
          stall_ex_c = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          state_next    = ST_RUN;
          wait_cnt_next = '0;
        end else if (wait_cnt_reg >= TIMEOUT_VAL) begin
          mem_err_c     = 1'b1;
          state_next    = ST_RUN;
          wait_cnt_next = '0;
        end else begin
          stall_fd_c    = 1'b1;
          stall_ex_c    = 1'b1;
          wait_cnt_next = wait_cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next    = ST_RUN;
        wait_cnt_next = '0;
      end
    endcase
  end

  // Outputs are forced low while reset is held, independent of the clock.
  assign stall_fd  = nrst && stall_fd_c;
  assign stall_ex  = nrst && stall_ex_c;
  assign flush_de  = nrst && flush_de_c;
  assign bubble_ex = nrst && bubble_ex_c;
  assign div_start = nrst && div_start_c;
  assign mem_err   = nrst && mem_err_c;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stall_cnt_reg <= 16'd0;
    end else if (stall_fd && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl
// Randomized and directed stimulus for pipe_ctrl, checked every cycle
// against a behavioural model of the controller's rules.
module tb_pipe_ctrl;

  localparam int TMO   = 16;
  localparam int M_RUN = 0;
  localparam int M_DIV = 1;
  localparam int M_MEM = 2;

  logic        clk;
  logic        nrst;
  logic [4:0]  rs1_3, rs2_3, rd4;
  logic        use_rs1_3, use_rs2_3, we4, load4, div4, div_done;
  logic        mem_req4, mem_ready, redirect4;
  logic        stall_fd, stall_ex, flush_de, bubble_ex, div_start, mem_err;
  logic [15:0] stall_cnt;

  pipe_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .rs1_3     (rs1_3),
    .rs2_3     (rs2_3),
    .use_rs1_3 (use_rs1_3),
    .use_rs2_3 (use_rs2_3),
    .rd4       (rd4),
    .we4       (we4),
    .load4     (load4),
    .div4      (div4),
    .div_done  (div_done),
    .mem_req4  (mem_req4),
    .mem_ready (mem_ready),
    .redirect4 (redirect4),
    .stall_fd  (stall_fd),
    .stall_ex  (stall_ex),
    .flush_de  (flush_de),
    .bubble_ex (bubble_ex),
    .div_start (div_start),
    .mem_err   (mem_err),
    .stall_cnt (stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  int m_mode;
  int m_wait;
  int m_scnt;
  bit e_fd, e_ex, e_fl, e_bx, e_ds, e_me;

  // observed-event tallies for directed scenarios
  int obs_fd, obs_ds, obs_me;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    rs1_3 = 5'd0; rs2_3 = 5'd0; rd4 = 5'd0;
    use_rs1_3 = 1'b0; use_rs2_3 = 1'b0; we4 = 1'b0; load4 = 1'b0;
    div4 = 1'b0; div_done = 1'b0; mem_req4 = 1'b0; mem_ready = 1'b0;
    redirect4 = 1'b0;
  endtask

  task automatic model_reset();
    m_mode = M_RUN;
    m_wait = 0;
    m_scnt = 0;
  endtask

  // Expected outputs and next mode from the controller rules.
  task automatic model_eval(output int nx_mode, output int nx_wait);
    bit hz;
    hz = load4 && we4 && (rd4 != 0) &&
         ((use_rs1_3 && rs1_3 == rd4) || (use_rs2_3 && rs2_3 == rd4));
    {e_fd, e_ex, e_fl, e_bx, e_ds, e_me} = '0;
    nx_mode = m_mode;
    nx_wait = m_wait;
    if (m_mode == M_RUN) begin
      if (redirect4) begin
        e_fl = 1; e_bx = 1;
      end else if (mem_req4 && !mem_ready) begin
        e_fd = 1; e_ex = 1; nx_mode = M_MEM; nx_wait = 1;
      end else if (div4) begin
        e_ds = 1; e_fd = 1; e_ex = 1; nx_mode = M_DIV;
      end else if (hz) begin
        e_fd = 1; e_bx = 1;
      end
    end else if (m_mode == M_DIV) begin
      if (div_done) nx_mode = M_RUN;
      else begin e_fd = 1; e_ex = 1; end
    end else begin
      if (mem_ready) begin
        nx_mode = M_RUN; nx_wait = 0;
      end else if (m_wait >= TMO) begin
        e_me = 1; nx_mode = M_RUN; nx_wait = 0;
      end else begin
        e_fd = 1; e_ex = 1; nx_wait = m_wait + 1;
      end
    end
  endtask

  // Inputs already driven (at posedge+1). Check mid-cycle, then advance
  // the model across the next rising edge.
  task automatic step(input bit do_chk);
    int nx_mode, nx_wait;
    #2;
    model_eval(nx_mode, nx_wait);
    if (do_chk) begin
      check("stall_fd",  32'(stall_fd),  32'(e_fd));
      check("stall_ex",  32'(stall_ex),  32'(e_ex));
      check("flush_de",  32'(flush_de),  32'(e_fl));
      check("bubble_ex", 32'(bubble_ex), 32'(e_bx));
      check("div_start", 32'(div_start), 32'(e_ds));
      check("mem_err",   32'(mem_err),   32'(e_me));
      check("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
    end
    obs_fd += int'(stall_fd);
    obs_ds += int'(div_start);
    obs_me += int'(mem_err);
    @(posedge clk);
    m_mode = nx_mode;
    m_wait = nx_wait;
    if (e_fd && m_scnt < 65535) m_scnt++;
    #1;
  endtask

  task automatic clear_tally();
    obs_fd = 0; obs_ds = 0; obs_me = 0;
  endtask

  initial begin
    int base;
    nrst = 1'b0;
    idle_inputs();
    model_reset();
    clear_tally();
    repeat (3) @(posedge clk);
    #1;
    check("rst_stall_fd",  32'(stall_fd),  32'd0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    nrst = 1'b1;

    // load-use hazard, then same with rd4=0
    clear_tally();
    load4 = 1; we4 = 1; rd4 = 5'd5; rs1_3 = 5'd5; use_rs1_3 = 1;
    step(1);
    check("lu_bubble", 32'(e_bx), 32'd1);
    idle_inputs();
    step(1);
    check("lu_cnt", 32'(stall_cnt), 32'd1);
    load4 = 1; we4 = 1; rd4 = 5'd0; rs1_3 = 5'd0; use_rs1_3 = 1;
    step(1);
    check("lu_rd0_fd", 32'(obs_fd), 32'd1);
    $display("[TB] load-use: stall cycles=%0d stall_cnt=%0d", obs_fd, stall_cnt);

    // divide: div_done 9 cycles after the div4 cycle
    idle_inputs();
    clear_tally();
    base = int'(stall_cnt);
    div4 = 1;
    step(1);
    div4 = 0;
    repeat (8) step(1);
    div_done = 1;
    step(1);
    div_done = 0;
    step(1);
    check("div_fd_cycles", 32'(obs_fd), 32'd9);
    check("div_starts", 32'(obs_ds), 32'd1);
    check("div_cnt", 32'(stall_cnt), 32'(base + 9));
    $display("[TB] divide: stall cycles=%0d starts=%0d", obs_fd, obs_ds);

    // memory timeout
    clear_tally();
    mem_req4 = 1; mem_ready = 0;
    step(1);
    mem_req4 = 0;
    repeat (TMO) step(1);
    check("mem_fd_cycles", 32'(obs_fd), 32'(TMO));
    check("mem_errs", 32'(obs_me), 32'd1);
    step(1);
    check("mem_after_fd", 32'(stall_fd), 32'd0);
    $display("[TB] mem timeout: stall cycles=%0d errs=%0d", obs_fd, obs_me);

    // redirect overrides everything
    clear_tally();
    redirect4 = 1; div4 = 1; load4 = 1; we4 = 1; rd4 = 5'd7; rs2_3 = 5'd7; use_rs2_3 = 1;
    step(1);
    check("redir_flush", 32'(e_fl), 32'd1);
    check("redir_nodiv", 32'(obs_ds + obs_fd), 32'd0);
    idle_inputs();
    $display("[TB] redirect: flush=%0d div_start=%0d", e_fl, obs_ds);

    // reset mid DIV_WAIT
    clear_tally();
    div4 = 1;
    step(1);
    div4 = 0;
    step(1);
    step(1);
    #1;
    nrst = 1'b0;
    div4 = 1;
    #1;
    check("rstmid_fd", 32'(stall_fd), 32'd0);
    check("rstmid_ex", 32'(stall_ex), 32'd0);
    check("rstmid_ds", 32'(div_start), 32'd0);
    check("rstmid_cnt", 32'(stall_cnt), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    idle_inputs();
    nrst = 1'b1;
    step(1);
    div_done = 1;
    step(1);
    div_done = 0;
    step(1);
    $display("[TB] reset mid divide: stall_cnt=%0d", stall_cnt);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rs1_3     = 5'($urandom_range(0, 3));
      rs2_3     = 5'($urandom_range(0, 3));
      rd4       = 5'($urandom_range(0, 3));
      use_rs1_3 = 1'($urandom_range(0, 1));
      use_rs2_3 = 1'($urandom_range(0, 1));
      we4       = ($urandom_range(0, 3) != 0);
      load4     = ($urandom_range(0, 1) != 0);
      div4      = ($urandom_range(0, 7) == 0);
      div_done  = ($urandom_range(0, 5) == 0);
      mem_req4  = ($urandom_range(0, 3) == 0);
      mem_ready = ($urandom_range(0, 9) < 3);
      redirect4 = ($urandom_range(0, 7) == 0);
      step(1);
      $display("[TB] rand %0d: mode=%0d fd=%0b ex=%0b fl=%0b bx=%0b ds=%0b me=%0b cnt=%0d",
               i, m_mode, stall_fd, stall_ex, flush_de, bubble_ex, div_start, mem_err, stall_cnt);
    end

    // saturation: park in DIV_WAIT
    idle_inputs();
    div_done = 1;
    step(1);
    step(1);
    div_done = 0;
    div4 = 1;
    step(1);
    div4 = 0;
    for (int i = 0; i < 70000; i++) step(0);
    check("sat_cnt", 32'(stall_cnt), 32'h0000_FFFF);
    check("sat_model", 32'(stall_cnt), 32'(m_scnt));
    step(1);
    check("sat_hold", 32'(stall_cnt), 32'h0000_FFFF);
    $display("[TB] saturation: stall_cnt=%0h", stall_cnt);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
